// File: rtl/jtdd_rom_arb_if.sv
// SDRAM read-port bundle between the ROM arbiter and the SDRAM controller.
// The arbiter is the master; the controller answers with ack and data pulses.
interface jtdd_rom_arb_if #(
    parameter int AW = 22
) ();
    logic [AW-1:0] sdram_addr;
    logic          sdram_req;
    logic          sdram_ack;
    logic          data_ok;
    logic [15:0]   sdram_dout;

    modport master (
        output sdram_addr,
        output sdram_req,
        input  sdram_ack,
        input  data_ok,
        input  sdram_dout
    );

    modport slave (
        input  sdram_addr,
        input  sdram_req,
        output sdram_ack,
        output data_ok,
        output sdram_dout
    );
endinterface

// File: rtl/jtdd_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among char/scroll/object
// graphics ROM requesters, with a one-word cache per requester.
module jtdd_rom_arb #(
    parameter int                  SDRAM_AW    = 22,
    parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
    parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h04000,
    parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h24000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    input  logic [14:0]           char_addr,
    output logic [7:0]            char_data,
    output logic                  char_ok,
    input  logic [16:0]           scr_addr,
    output logic [15:0]           scr_data,
    output logic                  scr_ok,
    input  logic [17:0]           obj_addr,
    output logic [15:0]           obj_data,
    output logic                  obj_ok,
    jtdd_rom_arb_if.master        sdram
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    localparam logic [1:0] S_CHAR = 2'd0;
    localparam logic [1:0] S_SCR  = 2'd1;
    localparam logic [1:0] S_OBJ  = 2'd2;

    state_t              state, state_nxt;
    logic [1:0]          sel, sel_nxt;
    logic [1:0]          ptr, ptr_nxt;
    logic [2:0]          valid, valid_nxt;
    logic [13:0]         char_tag, char_tag_nxt;
    logic [16:0]         scr_tag, scr_tag_nxt;
    logic [17:0]         obj_tag, obj_tag_nxt;
    logic [15:0]         char_word, char_word_nxt;
    logic [15:0]         scr_word, scr_word_nxt;
    logic [15:0]         obj_word, obj_word_nxt;
    logic                req, req_nxt;
    logic [SDRAM_AW-1:0] addr, addr_nxt;

    logic [SDRAM_AW-1:0] char_wa, scr_wa, obj_wa;
    logic [2:0]          hit, pend;
    logic [1:0]          pick;

    assign char_wa = CHAR_OFFSET + SDRAM_AW'(char_addr[14:1]);
    assign scr_wa  = SCR_OFFSET + SDRAM_AW'(scr_addr);
    assign obj_wa  = OBJ_OFFSET + SDRAM_AW'(obj_addr);

    assign hit[0] = valid[0] & (char_tag == char_addr[14:1]);
    assign hit[1] = valid[1] & (scr_tag == scr_addr);
    assign hit[2] = valid[2] & (obj_tag == obj_addr);
    assign pend   = ~hit;

    assign char_ok   = hit[0];
    assign scr_ok    = hit[1];
    assign obj_ok    = hit[2];
    assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];
    assign scr_data  = scr_word;
    assign obj_data  = obj_word;

    assign sdram.sdram_req  = req;
    assign sdram.sdram_addr = addr;

    // First pending slot, searching from the round-robin pointer.
    always_comb begin
        pick = S_CHAR;
        case (ptr)
            S_SCR:
                if (pend[1])      pick = S_SCR;
                else if (pend[2]) pick = S_OBJ;
                else              pick = S_CHAR;
            S_OBJ:
                if (pend[2])      pick = S_OBJ;
                else if (pend[0]) pick = S_CHAR;
                else              pick = S_SCR;
            default:
                if (pend[0])      pick = S_CHAR;
                else if (pend[1]) pick = S_SCR;
                else              pick = S_OBJ;
        endcase
    end

    // Next-state and datapath update; a download overrides everything.
    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        ptr_nxt       = ptr;
        valid_nxt     = valid;
        char_tag_nxt  = char_tag;
        scr_tag_nxt   = scr_tag;
        obj_tag_nxt   = obj_tag;
        char_word_nxt = char_word;
        scr_word_nxt  = scr_word;
        obj_word_nxt  = obj_word;
        req_nxt       = req;
        addr_nxt      = addr;
        if (downloading) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            valid_nxt = 3'b000;
        end else begin
            case (state)
                IDLE:
                    if (|pend) begin
                        sel_nxt         = pick;
                        req_nxt         = 1'b1;
                        state_nxt       = WAIT_ACK;
                        valid_nxt[pick] = 1'b0;
                        case (pick)
                            S_CHAR: begin
                                char_tag_nxt = char_addr[14:1];
                                addr_nxt     = char_wa;
                            end
                            S_SCR: begin
                                scr_tag_nxt = scr_addr;
                                addr_nxt    = scr_wa;
                            end
                            default: begin
                                obj_tag_nxt = obj_addr;
                                addr_nxt    = obj_wa;
                            end
                        endcase
                    end
                WAIT_ACK:
                    if (sdram.sdram_ack) begin
                        req_nxt   = 1'b0;
                        state_nxt = WAIT_DATA;
                    end
                WAIT_DATA:
                    if (sdram.data_ok) begin
                        valid_nxt[sel] = 1'b1;
                        ptr_nxt   = (sel == S_OBJ) ? S_CHAR : sel + 2'd1;
                        state_nxt = IDLE;
                        case (sel)
                            S_CHAR:  char_word_nxt = sdram.sdram_dout;
                            S_SCR:   scr_word_nxt  = sdram.sdram_dout;
                            default: obj_word_nxt  = sdram.sdram_dout;
                        endcase
                    end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and cache registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= S_CHAR;
            ptr       <= S_CHAR;
            valid     <= 3'b000;
            char_tag  <= '0;
            scr_tag   <= '0;
            obj_tag   <= '0;
            char_word <= '0;
            scr_word  <= '0;
            obj_word  <= '0;
            req       <= 1'b0;
            addr      <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            ptr       <= ptr_nxt;
            valid     <= valid_nxt;
            char_tag  <= char_tag_nxt;
            scr_tag   <= scr_tag_nxt;
            obj_tag   <= obj_tag_nxt;
            char_word <= char_word_nxt;
            scr_word  <= scr_word_nxt;
            obj_word  <= obj_word_nxt;
            req       <= req_nxt;
            addr      <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: SDRAM responder driven from tasks,
// expected request addresses queued and popped per request.
module tb_jtdd_rom_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b1;
    logic [14:0] char_addr = '0;
    logic [16:0] scr_addr = '0;
    logic [17:0] obj_addr = '0;
    logic [7:0]  char_data;
    logic [15:0] scr_data, obj_data;
    logic        char_ok, scr_ok, obj_ok;

    logic        w_dl = 1'b1;
    logic [14:0] w_char_addr = '0;
    logic [16:0] w_scr_addr = '0;
    logic [17:0] w_obj_addr = 18'h00002;
    logic [7:0]  w_char_data;
    logic [15:0] w_scr_data, w_obj_data;
    logic        w_char_ok, w_scr_ok, w_obj_ok;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];
    logic [21:0] wq[$];

    jtdd_rom_arb_if #(.AW(22)) bus ();
    jtdd_rom_arb_if #(.AW(22)) wbus ();

    jtdd_rom_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .char_addr   (char_addr),
        .char_data   (char_data),
        .char_ok     (char_ok),
        .scr_addr    (scr_addr),
        .scr_data    (scr_data),
        .scr_ok      (scr_ok),
        .obj_addr    (obj_addr),
        .obj_data    (obj_data),
        .obj_ok      (obj_ok),
        .sdram       (bus.master)
    );

    jtdd_rom_arb #(.OBJ_OFFSET(22'h3FFFFF)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (w_dl),
        .char_addr   (w_char_addr),
        .char_data   (w_char_data),
        .char_ok     (w_char_ok),
        .scr_addr    (w_scr_addr),
        .scr_data    (w_scr_data),
        .scr_ok      (w_scr_ok),
        .obj_addr    (w_obj_addr),
        .obj_data    (w_obj_data),
        .obj_ok      (w_obj_ok),
        .sdram       (wbus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic ok_of(int s);
        case (s)
            0:       return char_ok;
            1:       return scr_ok;
            default: return obj_ok;
        endcase
    endfunction

    // Wait for a request, check its address against the scoreboard,
    // then acknowledge after ack_dly cycles.
    task automatic do_req_ack(int ack_dly);
        int n = 0;
        logic [21:0] e;
        while (!bus.sdram_req && n < 50) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(bus.sdram_req), 32'd1);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'(exp_q.size()), 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("req_addr", 32'(bus.sdram_addr), 32'(e));
        repeat (ack_dly) tick();
        chk("req_hold", 32'(bus.sdram_req), 32'd1);
        chk("addr_hold", 32'(bus.sdram_addr), 32'(e));
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        chk("req_drop", 32'(bus.sdram_req), 32'd0);
    endtask

    // Deliver data dat_dly cycles after the ack; ok must rise only then.
    task automatic do_data(int dat_dly, logic [15:0] d, int slot);
        repeat (dat_dly - 1) tick();
        chk("ok_before", 32'(ok_of(slot)), 32'd0);
        bus.data_ok    = 1'b1;
        bus.sdram_dout = d;
        tick();
        bus.data_ok    = 1'b0;
        bus.sdram_dout = $urandom();
    endtask

    initial begin
        int n;
        int reqs;
        bus.sdram_ack  = 1'b0;
        bus.data_ok    = 1'b0;
        bus.sdram_dout = '0;
        wbus.sdram_ack  = 1'b0;
        wbus.data_ok    = 1'b0;
        wbus.sdram_dout = '0;

        // Reset with random stimulus
        repeat (4) begin
            char_addr      = 15'($urandom());
            scr_addr       = 17'($urandom());
            obj_addr       = 18'($urandom());
            downloading    = 1'($urandom());
            bus.sdram_ack  = 1'($urandom());
            bus.data_ok    = 1'($urandom());
            bus.sdram_dout = 16'($urandom());
            tick();
        end
        chk("rst_req", 32'(bus.sdram_req), 32'd0);
        chk("rst_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
        chk("rst_data", {char_data, scr_data}, 32'd0);
        chk("rst_odata", 32'(obj_data), 32'd0);
        bus.sdram_ack = 1'b0;
        bus.data_ok   = 1'b0;
        downloading   = 1'b1;
        tick();
        rst_n = 1'b1;
        reqs = 0;
        repeat (100) begin
            tick();
            if (bus.sdram_req) reqs++;
        end
        chk("dl_noreq", 32'(reqs), 32'd0);

        // All three miss; round-robin order char, scr, obj
        char_addr = 15'h0003;
        scr_addr  = 17'h00123;
        obj_addr  = 18'h00456;
        exp_q.push_back(22'h000001);
        exp_q.push_back(22'h004123);
        exp_q.push_back(22'h024456);
        downloading = 1'b0;
        do_req_ack(2);
        do_data(3, 16'hA55A, 0);
        chk("char_ok", 32'(char_ok), 32'd1);
        chk("char_hi", 32'(char_data), 32'hA5);
        chk("scr_ok0", 32'(scr_ok), 32'd0);
        do_req_ack(1);
        do_data(2, 16'h1234, 1);
        chk("scr_ok", 32'(scr_ok), 32'd1);
        chk("scr_data", 32'(scr_data), 32'h1234);
        chk("obj_ok0", 32'(obj_ok), 32'd0);
        do_req_ack(3);
        do_data(1, 16'hBEEF, 2);
        chk("obj_ok", 32'(obj_ok), 32'd1);
        chk("obj_data", 32'(obj_data), 32'hBEEF);

        // Same word, other byte: immediate hit, no request
        char_addr = 15'h0002;
        #1;
        chk("char_hit", 32'(char_ok), 32'd1);
        chk("char_lo", 32'(char_data), 32'h5A);
        reqs = 0;
        repeat (10) begin
            tick();
            if (bus.sdram_req) reqs++;
        end
        chk("hit_noreq", 32'(reqs), 32'd0);

        // Scroll address changes while the fetch is outstanding
        scr_addr = 17'h00010;
        exp_q.push_back(22'h004010);
        do_req_ack(2);
        scr_addr = 17'h00020;
        exp_q.push_back(22'h004020);
        do_data(3, 16'h7777, 1);
        chk("stale_ok", 32'(scr_ok), 32'd0);
        chk("stale_data", 32'(scr_data), 32'h7777);
        do_req_ack(1);
        do_data(2, 16'h8888, 1);
        chk("refetch_ok", 32'(scr_ok), 32'd1);
        chk("refetch_data", 32'(scr_data), 32'h8888);

        // Download aborts an object fetch in WAIT_DATA
        obj_addr = 18'h00100;
        exp_q.push_back(22'h024100);
        do_req_ack(1);
        downloading = 1'b1;
        tick();
        bus.data_ok    = 1'b1;
        bus.sdram_dout = 16'hDEAD;
        tick();
        bus.data_ok    = 1'b0;
        chk("abort_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
        chk("abort_req", 32'(bus.sdram_req), 32'd0);
        reqs = 0;
        repeat (20) begin
            tick();
            if (bus.sdram_req) reqs++;
        end
        chk("abort_noreq", 32'(reqs), 32'd0);
        exp_q.push_back(22'h024100);
        exp_q.push_back(22'h000001);
        exp_q.push_back(22'h004020);
        downloading = 1'b0;
        do_req_ack(1);
        do_data(1, 16'h0BB0, 2);
        do_req_ack(2);
        do_data(2, 16'h1CC1, 0);
        do_req_ack(1);
        do_data(1, 16'h2DD2, 1);
        chk("re_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd7);
        chk("re_obj", 32'(obj_data), 32'h0BB0);
        chk("re_char", 32'(char_data), 32'hC1);
        chk("re_scr", 32'(scr_data), 32'h2DD2);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        // Offset wrap on the object region
        wq.push_back(22'h000000);
        wq.push_back(22'h004000);
        wq.push_back(22'h000001);
        w_dl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!wbus.sdram_req && n < 50) begin
                tick();
                n++;
            end
            chk("w_req", 32'(wbus.sdram_req), 32'd1);
            chk("w_addr", 32'(wbus.sdram_addr), 32'(wq.pop_front()));
            wbus.sdram_ack = 1'b1;
            tick();
            wbus.sdram_ack = 1'b0;
            tick();
            wbus.data_ok    = 1'b1;
            wbus.sdram_dout = 16'(16'h4440 + i);
            tick();
            wbus.data_ok = 1'b0;
        end
        chk("w_obj_ok", 32'(w_obj_ok), 32'd1);
        chk("w_obj_data", 32'(w_obj_data), 32'h4442);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
